// File: rtl/ssy_pkg.sv
// Shared types for the ssy request issuer: FSM state encoding and completion status.
package ssy_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } issuer_state_t;

  typedef enum logic [1:0] {
    GRANTED = 2'd0,
    DROPPED = 2'd1
  } done_status_t;

endpackage

// File: rtl/ssy_job_fifo.sv
// Job ID FIFO: power-of-two depth, wrapping pointers, registered occupancy count.
module ssy_job_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [ID_W-1:0]  push_id,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [ID_W-1:0]  head,
  output logic [PTR_W:0]   count
);

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_id;
  end

endmodule

// File: rtl/ssy_req_issuer.sv
// Issues buffered job IDs to the ssy arbiter one at a time, retrying on grant
// timeout and reporting each job's outcome and grant latency.
module ssy_req_issuer
  import ssy_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ID_W      = 4,
  parameter int TIMEOUT   = 15,
  parameter int MAX_RETRY = 2,
  parameter int LAT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  input  logic [ID_W-1:0]  job_id,
  output logic             job_ready,
  output logic             request,
  input  logic             idle,
  input  logic             granted,
  output logic             done_valid,
  output logic [ID_W-1:0]  done_id,
  output logic [1:0]       done_status,
  output logic [LAT_W-1:0] done_latency,
  output logic             spurious_grant
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  localparam logic [LAT_W-1:0] TMO_LAST = LAT_W'(TIMEOUT - 1);

  issuer_state_t    state_q, state_d;
  logic [LAT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [ID_W-1:0]  done_id_q, done_id_d;
  done_status_t     done_status_q, done_status_d;
  logic [LAT_W-1:0] done_latency_q, done_latency_d;
  logic             spurious_q, spurious_d;

  logic             push, pop, full, empty, timeout;
  logic [ID_W-1:0]  head;
  logic [CNT_W-1:0] count;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ssy_job_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .push_id (job_id),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head),
    .count   (count)
  );

  assign job_ready      = !full;
  assign push           = job_valid && !full;
  assign pop            = (state_q == REPORT);
  // Combinational in idle so a request never appears while ssy is busy.
  assign request        = (state_q == ISSUE) && idle;
  assign done_valid     = (state_q == REPORT);
  assign done_id        = done_id_q;
  assign done_status    = done_status_q;
  assign done_latency   = done_latency_q;
  assign spurious_grant = spurious_q;
  // The counter starts at 0, so the last WAIT cycle is TIMEOUT-1.
  assign timeout        = (wait_cnt_q == TMO_LAST);

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    retry_d        = retry_q;
    done_id_d      = done_id_q;
    done_status_d  = done_status_q;
    done_latency_d = done_latency_q;
    spurious_d     = spurious_q | (granted && (state_q != WAIT));
    case (state_q)
      EMPTY: begin
        if (push || !empty) state_d = ISSUE;
      end
      ISSUE: begin
        if (idle) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (granted) begin
          state_d        = REPORT;
          done_id_d      = head;
          done_status_d  = GRANTED;
          done_latency_d = sat_inc(wait_cnt_q);
        end else if (timeout) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ISSUE;
          end else begin
            state_d        = REPORT;
            done_id_d      = head;
            done_status_d  = DROPPED;
            done_latency_d = '0;
          end
        end
      end
      REPORT: begin
        retry_d = '0;
        // Head is popped this cycle; a concurrent push keeps the FIFO non-empty.
        if (push || (count > CNT_W'(1))) state_d = ISSUE;
        else                             state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= EMPTY;
      wait_cnt_q     <= '0;
      retry_q        <= '0;
      done_id_q      <= '0;
      done_status_q  <= GRANTED;
      done_latency_q <= '0;
      spurious_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      retry_q        <= retry_d;
      done_id_q      <= done_id_d;
      done_status_q  <= done_status_d;
      done_latency_q <= done_latency_d;
      spurious_q     <= spurious_d;
    end
  end

endmodule

// File: tb/tb_ssy_req_issuer.sv
// Directed bench for ssy_req_issuer: single job, idle gating, timeout/drop,
// FIFO full, grant/timeout boundary, spurious grant and mid-operation reset.
module tb_ssy_req_issuer;

  localparam int DEPTH     = 4;
  localparam int ID_W      = 4;
  localparam int TIMEOUT   = 15;
  localparam int MAX_RETRY = 2;
  localparam int LAT_W     = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             job_valid;
  logic [ID_W-1:0]  job_id;
  logic             job_ready;
  logic             request;
  logic             idle;
  logic             granted;
  logic             done_valid;
  logic [ID_W-1:0]  done_id;
  logic [1:0]       done_status;
  logic [LAT_W-1:0] done_latency;
  logic             spurious_grant;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssy_req_issuer #(
    .DEPTH     (DEPTH),
    .ID_W      (ID_W),
    .TIMEOUT   (TIMEOUT),
    .MAX_RETRY (MAX_RETRY),
    .LAT_W     (LAT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .job_valid      (job_valid),
    .job_id         (job_id),
    .job_ready      (job_ready),
    .request        (request),
    .idle           (idle),
    .granted        (granted),
    .done_valid     (done_valid),
    .done_id        (done_id),
    .done_status    (done_status),
    .done_latency   (done_latency),
    .spurious_grant (spurious_grant)
  );

  // Activity monitor, sampled mid-cycle.
  int cyc_n = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  int idle_viol = 0;
  int done_cyc_last = 0;
  int req_cyc[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (request) begin
        req_cnt <= req_cnt + 1;
        req_cyc.push_back(cyc_n);
      end
      if (request && !idle) idle_viol <= idle_viol + 1;
      if (done_valid) begin
        done_cnt      <= done_cnt + 1;
        done_cyc_last <= cyc_n;
      end
    end
    cyc_n <= cyc_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic [ID_W-1:0] id);
    job_valid = 1'b1;
    job_id    = id;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_req(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (request) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; job_valid = 1'b0; job_id = '0; idle = 1'b1; granted = 1'b0;
    repeat (3) tick();
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got %b want 1", job_ready); end
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL reset_request got %b want 0", request); end
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL reset_done_valid got %b want 0", done_valid); end
    checks++; if (done_id !== 4'd0) begin errors++; $display("FAIL reset_done_id got %0d want 0", done_id); end
    checks++; if (done_status !== 2'd0) begin errors++; $display("FAIL reset_done_status got %0d want 0", done_status); end
    checks++; if (done_latency !== 8'd0) begin errors++; $display("FAIL reset_done_latency got %0d want 0", done_latency); end
    checks++; if (spurious_grant !== 1'b0) begin errors++; $display("FAIL reset_spurious got %b want 0", spurious_grant); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int r0, d0;
    idle = 1'b1; r0 = req_cnt; d0 = done_cnt;
    push_job(4'd3);
    @(negedge clk);
    checks++; if (request !== 1'b1) begin errors++; $display("FAIL single_req_cycle got %b want 1", request); end
    tick();
    tick(); granted = 1'b1;
    tick(); granted = 1'b0;
    @(negedge clk);
    checks++; if (done_valid !== 1'b1) begin errors++; $display("FAIL single_done_valid got %b want 1", done_valid); end
    checks++; if (done_id !== 4'd3) begin errors++; $display("FAIL single_done_id got %0d want 3", done_id); end
    checks++; if (done_status !== 2'd0) begin errors++; $display("FAIL single_status got %0d want 0", done_status); end
    checks++; if (done_latency !== 8'd2) begin errors++; $display("FAIL single_latency got %0d want 2", done_latency); end
    tick();
    checks++; if (req_cnt - r0 != 1) begin errors++; $display("FAIL single_req_pulses got %0d want 1", req_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_pulses got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_idle_gating();
    int r0, hi;
    idle = 1'b0; r0 = req_cnt; hi = 0;
    push_job(4'd5);
    repeat (10) begin
      @(negedge clk);
      if (request) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL idle_low_requests got %0d want 0", hi); end
    tick(); idle = 1'b1;
    @(negedge clk);
    checks++; if (request !== 1'b1) begin errors++; $display("FAIL idle_rise_request got %b want 1", request); end
    tick(); granted = 1'b1;
    tick(); granted = 1'b0;
    @(negedge clk);
    checks++; if ({done_valid, done_id} !== {1'b1, 4'd5}) begin errors++; $display("FAIL idle_done got v=%b id=%0d want v=1 id=5", done_valid, done_id); end
    checks++; if (done_latency !== 8'd1) begin errors++; $display("FAIL idle_latency got %0d want 1", done_latency); end
    tick();
    checks++; if (req_cnt - r0 != 1) begin errors++; $display("FAIL idle_req_pulses got %0d want 1", req_cnt - r0); end
  endtask

  task automatic test_timeout();
    int r0;
    bit seen;
    idle = 1'b1; r0 = req_cnt;
    req_cyc.delete();
    push_job(4'd9);
    seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (done_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_done_seen got 0 want 1"); end
    checks++; if (done_status !== 2'd1) begin errors++; $display("FAIL timeout_status got %0d want 1", done_status); end
    checks++; if (done_latency !== 8'd0) begin errors++; $display("FAIL timeout_latency got %0d want 0", done_latency); end
    checks++; if (done_id !== 4'd9) begin errors++; $display("FAIL timeout_id got %0d want 9", done_id); end
    tick();
    checks++; if (req_cnt - r0 != 3) begin errors++; $display("FAIL timeout_req_pulses got %0d want 3", req_cnt - r0); end
    if (req_cyc.size() == 3) begin
      checks++; if (req_cyc[1] - req_cyc[0] != 16) begin errors++; $display("FAIL timeout_gap1 got %0d want 16", req_cyc[1] - req_cyc[0]); end
      checks++; if (req_cyc[2] - req_cyc[1] != 16) begin errors++; $display("FAIL timeout_gap2 got %0d want 16", req_cyc[2] - req_cyc[1]); end
      checks++; if (done_cyc_last - req_cyc[2] != 16) begin errors++; $display("FAIL timeout_drop_delay got %0d want 16", done_cyc_last - req_cyc[2]); end
    end
  endtask

  task automatic test_fifo_full();
    int d0;
    idle = 1'b0; d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      job_valid = 1'b1;
      job_id    = ID_W'(k);
      tick();
    end
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low got %b want 0", job_ready); end
    job_id = 4'd4;
    repeat (3) tick();
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold got %b want 0", job_ready); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL full_no_done got %0d want 0", done_cnt - d0); end
    idle = 1'b1;
    fork
      begin
        bit acc;
        for (int k = 4; k < 6; k++) begin
          job_id = ID_W'(k);
          acc = 1'b0;
          for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            if (job_ready) begin
              @(posedge clk);
              #1;
              acc = 1'b1;
            end
          end
          checks++; if (!acc) begin errors++; $display("FAIL full_accept id=%0d got 0 want 1", k); end
        end
        job_valid = 1'b0;
      end
      begin
        bit seen;
        logic [ID_W-1:0] exp_id;
        for (int k = 0; k < 6; k++) begin
          exp_id = ID_W'(k);
          wait_req(60, seen);
          checks++; if (!seen) begin errors++; $display("FAIL full_request k=%0d got 0 want 1", k); end
          tick(); granted = 1'b1;
          tick(); granted = 1'b0;
          @(negedge clk);
          checks++; if ({done_valid, done_id} !== {1'b1, exp_id}) begin errors++; $display("FAIL full_order got v=%b id=%0d want v=1 id=%0d", done_valid, done_id, exp_id); end
          checks++; if (done_latency !== 8'd1) begin errors++; $display("FAIL full_latency k=%0d got %0d want 1", k, done_latency); end
          if (k == 0) begin
            checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL full_ready_on_pop got %b want 0", job_ready); end
          end
        end
      end
    join
    tick();
    checks++; if (done_cnt - d0 != 6) begin errors++; $display("FAIL full_done_count got %0d want 6", done_cnt - d0); end
  endtask

  task automatic test_boundary();
    int r0;
    idle = 1'b1; r0 = req_cnt;
    push_job(4'd7);
    @(negedge clk);
    checks++; if (request !== 1'b1) begin errors++; $display("FAIL bound_request got %b want 1", request); end
    repeat (15) @(posedge clk);
    #1 granted = 1'b1;
    tick(); granted = 1'b0;
    @(negedge clk);
    checks++; if ({done_valid, done_id} !== {1'b1, 4'd7}) begin errors++; $display("FAIL bound_done got v=%b id=%0d want v=1 id=7", done_valid, done_id); end
    checks++; if (done_status !== 2'd0) begin errors++; $display("FAIL bound_status got %0d want 0", done_status); end
    checks++; if (done_latency !== 8'd15) begin errors++; $display("FAIL bound_latency got %0d want 15", done_latency); end
    tick();
    checks++; if (req_cnt - r0 != 1) begin errors++; $display("FAIL bound_req_pulses got %0d want 1", req_cnt - r0); end
  endtask

  task automatic test_spurious();
    int d0;
    d0 = done_cnt;
    tick();
    checks++; if (spurious_grant !== 1'b0) begin errors++; $display("FAIL spur_before got %b want 0", spurious_grant); end
    granted = 1'b1;
    tick(); granted = 1'b0;
    repeat (3) tick();
    checks++; if (spurious_grant !== 1'b1) begin errors++; $display("FAIL spur_set got %b want 1", spurious_grant); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL spur_no_done got %0d want 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int r0, d0;
    bit seen;
    idle = 1'b1;
    push_job(4'd11);
    wait_req(5, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_request got 0 want 1"); end
    repeat (3) tick();
    #1 reset_n = 1'b0;
    #1;
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL rstmid_request_low got %b want 0", request); end
    checks++; if (done_valid !== 1'b0) begin errors++; $display("FAIL rstmid_done_valid got %b want 0", done_valid); end
    checks++; if (done_id !== 4'd0) begin errors++; $display("FAIL rstmid_done_id got %0d want 0", done_id); end
    checks++; if (done_latency !== 8'd0) begin errors++; $display("FAIL rstmid_latency got %0d want 0", done_latency); end
    checks++; if (spurious_grant !== 1'b0) begin errors++; $display("FAIL rstmid_spurious got %b want 0", spurious_grant); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL rstmid_job_ready got %b want 1", job_ready); end
    tick(); tick();
    reset_n = 1'b1;
    r0 = req_cnt; d0 = done_cnt;
    repeat (25) tick();
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstmid_lost_done got %0d want 0", done_cnt - d0); end
    checks++; if (req_cnt != r0) begin errors++; $display("FAIL rstmid_lost_req got %0d want 0", req_cnt - r0); end
    idle = 1'b0;
    push_job(4'd12);
    idle = 1'b1;
    #1;
    checks++; if (request !== 1'b1) begin errors++; $display("FAIL rstasync_pre got %b want 1", request); end
    reset_n = 1'b0;
    #1;
    checks++; if (request !== 1'b0) begin errors++; $display("FAIL rstasync_drop got %b want 0", request); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_idle_gating();
    test_timeout();
    test_fifo_full();
    test_boundary();
    test_spurious();
    test_reset_mid();
    checks++; if (idle_viol != 0) begin errors++; $display("FAIL request_while_busy got %0d want 0", idle_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
